// File: rtl/io_buffer.sv
// Execute-stage I/O unit: byte FIFOs between the core and the UART, with
// a 4-byte cin_int pop, a single-byte out push and a combinational stall.
module io_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_issued_e,
    input  logic        out_issued_e,
    input  logic [31:0] out_data_e,
    output logic [31:0] in_data_e,
    output logic        io_stall,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_overrun,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   WORD = (DEPTH_LOG2+1)'(4);
    localparam logic [DEPTH_LOG2:0]   ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] P1   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] P2   = DEPTH_LOG2'(2);
    localparam logic [DEPTH_LOG2-1:0] P3   = DEPTH_LOG2'(3);

    logic [7:0]            r_rx_mem [DEPTH];
    logic [7:0]            r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_rp, r_rx_wp, r_tx_rp, r_tx_wp;
    logic [DEPTH_LOG2:0]   r_rx_cnt, r_tx_cnt;
    logic [DEPTH_LOG2:0]   w_rx_cnt_nxt, w_tx_cnt_nxt;
    logic                  r_rx_overrun;
    logic                  w_rx_pop, w_rx_push, w_tx_push, w_tx_pop, w_tx_full;
    logic                  w_unused;

    assign w_unused = &{1'b0, out_data_e[31:8]};

    // cin_int needs a whole word; a pop frees room for a simultaneous rx byte
    assign w_rx_pop  = in_issued_e && (r_rx_cnt >= WORD);
    assign w_rx_push = rx_valid && ((r_rx_cnt < FULL) || w_rx_pop);
    assign w_tx_full = (r_tx_cnt == FULL);
    assign w_tx_push = out_issued_e && !w_tx_full;
    assign w_tx_pop  = tx_valid && tx_ready;

    assign io_stall  = (in_issued_e && (r_rx_cnt < WORD)) ||
                       (out_issued_e && w_tx_full);
    assign in_data_e = (w_rx_pop && !rst) ?
                       {r_rx_mem[r_rx_rp + P3], r_rx_mem[r_rx_rp + P2],
                        r_rx_mem[r_rx_rp + P1], r_rx_mem[r_rx_rp]} : 32'h0;

    assign tx_valid   = (r_tx_cnt != '0);
    assign tx_data    = tx_valid ? r_tx_mem[r_tx_rp] : 8'h0;
    assign rx_overrun = r_rx_overrun;

    always_comb begin
        w_rx_cnt_nxt = r_rx_cnt;
        if (w_rx_push) w_rx_cnt_nxt = w_rx_cnt_nxt + ONE;
        if (w_rx_pop)  w_rx_cnt_nxt = w_rx_cnt_nxt - WORD;
        w_tx_cnt_nxt = r_tx_cnt;
        if (w_tx_push) w_tx_cnt_nxt = w_tx_cnt_nxt + ONE;
        if (w_tx_pop)  w_tx_cnt_nxt = w_tx_cnt_nxt - ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
        if (!rst && w_tx_push) r_tx_mem[r_tx_wp] <= out_data_e[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_rp      <= '0;
            r_rx_wp      <= '0;
            r_rx_cnt     <= '0;
            r_tx_rp      <= '0;
            r_tx_wp      <= '0;
            r_tx_cnt     <= '0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_rx_push)            r_rx_wp      <= r_rx_wp + P1;
            if (w_rx_pop)             r_rx_rp      <= r_rx_rp + DEPTH_LOG2'(4);
            if (rx_valid && !w_rx_push) r_rx_overrun <= 1'b1;
            if (w_tx_push)            r_tx_wp      <= r_tx_wp + P1;
            if (w_tx_pop)             r_tx_rp      <= r_tx_rp + P1;
            r_rx_cnt <= w_rx_cnt_nxt;
            r_tx_cnt <= w_tx_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_io_buffer.sv
// Scoreboard bench for io_buffer (DEPTH_LOG2=2): expected cin_int words and
// tx bytes are queued at issue time and checked by a negedge monitor.
module tb_io_buffer;
    logic        clk = 1'b0;
    logic        rst, in_issued_e, out_issued_e, rx_valid, tx_ready;
    logic [31:0] out_data_e, in_data_e;
    logic [7:0]  rx_data, tx_data;
    logic        io_stall, rx_overrun, tx_valid;
    logic        run = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_rx[$];
    logic [7:0]  exp_tx[$];

    always #5 clk = ~clk;

    io_buffer #(.DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .in_issued_e(in_issued_e), .out_issued_e(out_issued_e),
        .out_data_e(out_data_e), .in_data_e(in_data_e), .io_stall(io_stall),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_overrun(rx_overrun),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a transfer
    always @(negedge clk) begin
        if (run && !rst) begin
            assert (!(in_issued_e && out_issued_e)) else $error("in and out issued together");
            if (in_issued_e && !io_stall) begin
                if (exp_rx.size() == 0) chk("in_data_unexpected", 32'd1, 32'd0);
                else chk("in_data", in_data_e, exp_rx.pop_front());
            end else begin
                chk("in_data_idle", in_data_e, 32'h0);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                else chk("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [4]  = '{8'h78, 8'h56, 8'h34, 8'h12};
        logic [7:0] t5 [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        rst = 1'b1; in_issued_e = 0; out_issued_e = 0; out_data_e = 0;
        rx_valid = 0; rx_data = 0; tx_ready = 0;
        cyc(); cyc();
        rst = 1'b0; run = 1'b1;
        @(negedge clk);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
        chk("rst_overrun", {31'h0, rx_overrun}, 32'd0);
        chk("rst_stall", {31'h0, io_stall}, 32'd0);

        // cin_int waits for four bytes, then returns them little-endian
        cyc();
        in_issued_e = 1;
        exp_rx.push_back(32'h12345678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("cin_empty_stall", {31'h0, io_stall}, 32'd1); cyc();
        end
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1; rx_data = t1[i];
            @(negedge clk); chk("cin_fill_stall", {31'h0, io_stall}, 32'd1); cyc();
        end
        rx_valid = 0;
        @(negedge clk); chk("cin_done_stall", {31'h0, io_stall}, 32'd0); cyc();
        @(negedge clk); chk("cin_drained_stall", {31'h0, io_stall}, 32'd1); cyc();
        in_issued_e = 0;

        // four outs queue, then drain back-to-back
        for (int k = 1; k <= 4; k++) begin
            out_issued_e = 1; out_data_e = 32'hAABBCC00 | k;
            exp_tx.push_back(8'(k));
            @(negedge clk); chk("out_stall", {31'h0, io_stall}, 32'd0); cyc();
        end
        out_issued_e = 0;
        @(negedge clk);
        chk("tx_valid_held", {31'h0, tx_valid}, 32'd1);
        chk("tx_head", {24'h0, tx_data}, 32'h01);
        cyc();
        tx_ready = 1;
        repeat (4) cyc();
        @(negedge clk); chk("tx_empty", {31'h0, tx_valid}, 32'd0);
        cyc();
        tx_ready = 0;

        // full tx FIFO stalls the 5th out; a head pop does not bypass
        for (int k = 1; k <= 4; k++) begin
            out_issued_e = 1; out_data_e = 32'h10 + k;
            exp_tx.push_back(8'(8'h10 + k));
            cyc();
        end
        out_data_e = 32'h15; exp_tx.push_back(8'h15);
        @(negedge clk); chk("tx_full_stall", {31'h0, io_stall}, 32'd1); cyc();
        @(negedge clk); chk("tx_full_stall2", {31'h0, io_stall}, 32'd1); cyc();
        tx_ready = 1;
        @(negedge clk); chk("tx_no_bypass", {31'h0, io_stall}, 32'd1); cyc();
        tx_ready = 0;
        @(negedge clk); chk("tx_unstall", {31'h0, io_stall}, 32'd0); cyc();
        out_issued_e = 0;
        tx_ready = 1;
        repeat (4) cyc();
        @(negedge clk); chk("tx_empty2", {31'h0, tx_valid}, 32'd0);
        cyc();
        tx_ready = 0;

        // rx overrun, then pop with a simultaneous push
        for (int i = 1; i <= 5; i++) begin
            rx_valid = 1; rx_data = 8'hA0 + 8'(i);
            @(negedge clk); chk("ovr_before", {31'h0, rx_overrun}, 32'd0); cyc();
        end
        rx_valid = 0;
        @(negedge clk); chk("ovr_set", {31'h0, rx_overrun}, 32'd1);
        cyc();
        in_issued_e = 1; rx_valid = 1; rx_data = 8'h99;
        exp_rx.push_back(32'hA4A3A2A1);
        @(negedge clk); chk("ovr_cin_stall", {31'h0, io_stall}, 32'd0); cyc();
        in_issued_e = 0;
        for (int i = 1; i <= 3; i++) begin
            rx_data = 8'hB0 + 8'(i); cyc();
        end
        rx_valid = 0; in_issued_e = 1;
        exp_rx.push_back(32'hB3B2B199);
        @(negedge clk); chk("cin_after_bypass", {31'h0, io_stall}, 32'd0); cyc();
        in_issued_e = 0;
        @(negedge clk); chk("ovr_sticky", {31'h0, rx_overrun}, 32'd1);
        cyc();

        // three back-to-back cin_int over a continuous byte stream
        exp_rx.push_back(32'h44332211);
        exp_rx.push_back(32'h88776655);
        exp_rx.push_back(32'hCCBBAA99);
        in_issued_e = 1;
        for (int i = 0; i < 12; i++) begin
            rx_valid = 1; rx_data = t5[i];
            @(negedge clk);
            chk("stream_stall", {31'h0, io_stall}, (i == 4 || i == 8) ? 32'd0 : 32'd1);
            cyc();
        end
        rx_valid = 0;
        @(negedge clk); chk("stream_last", {31'h0, io_stall}, 32'd0); cyc();
        in_issued_e = 0;

        // reset while stalled abandons everything
        tx_ready = 0;
        out_issued_e = 1; out_data_e = 32'h77; cyc();
        out_issued_e = 0;
        rx_valid = 1; rx_data = 8'hF1; cyc();
        rx_data = 8'hF2; cyc();
        rx_valid = 0; in_issued_e = 1;
        @(negedge clk); chk("pre_rst_stall", {31'h0, io_stall}, 32'd1); cyc();
        rst = 1; cyc();
        rst = 0; in_issued_e = 0;
        @(negedge clk);
        chk("mid_rst_overrun", {31'h0, rx_overrun}, 32'd0);
        chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        chk("mid_rst_tx_data", {24'h0, tx_data}, 32'd0);
        cyc();
        for (int i = 1; i <= 4; i++) begin
            rx_valid = 1; rx_data = 8'hE0 + 8'(i); cyc();
        end
        rx_valid = 0; in_issued_e = 1;
        exp_rx.push_back(32'hE4E3E2E1);
        @(negedge clk); chk("post_rst_cin", {31'h0, io_stall}, 32'd0); cyc();
        in_issued_e = 0;
        cyc();

        run = 0;
        chk("rx_sb_empty", exp_rx.size(), 32'd0);
        chk("tx_sb_empty", exp_tx.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/io_buffer.md
Name: io_buffer

Overview:
- Execute-stage I/O unit, directly downstream of the main decoder.
- Consumes the decoder's in_issued (cin_int) and out_issued (out) flags as they arrive in EX.
- Buffers bytes between the core and the UART rx/tx blocks. Supplies the 32-bit cin_int result on the result_src=111 writeback path.
- Raises a stall to the hazard unit when an I/O instruction cannot complete.

Parameters:
- DEPTH_LOG2, 4, log2 of the entry count of each byte FIFO (rx and tx). Legal range is 2..10.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- in_issued_e  input  1  cin_int is in EX this cycle
- out_issued_e  input  1  out is in EX this cycle
- out_data_e  input  32  rs1 value of the out instruction; bits [7:0] are transmitted
- in_data_e  output  32  cin_int result, little-endian {b3,b2,b1,b0}
- io_stall  output  1  hold IF/ID/EX; the instruction in EX does not complete
- rx_valid  input  1  one-cycle strobe from the UART receiver
- rx_data  input  8  received byte
- rx_overrun  output  1  sticky flag: a received byte was dropped
- tx_valid  output  1  tx FIFO non-empty
- tx_data  output  8  tx FIFO head byte
- tx_ready  input  1  UART transmitter accepts tx_data this cycle

Behaviour:
- Both FIFOs have DEPTH=2**DEPTH_LOG2 entries. Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. Each count is DEPTH_LOG2+1 bits wide, range 0..DEPTH.
- Reset, synchronous with priority over every other input:
  - all pointers and counts go to 0 and rx_overrun goes to 0;
  - tx_valid=0 and tx_data=0 in the following cycle;
  - any in-flight I/O instruction is abandoned, so no pop and no push happens in the reset cycle.
- The rx FIFO receives bytes:
  - push when rx_valid is high and (rx_count<DEPTH or a cin_int pop occurs in the same cycle);
  - otherwise the byte is discarded and rx_overrun is set, staying 1 until rst.
- cin_int:
  - io_stall = in_issued_e && rx_count<4. This is combinational, with no registered delay.
  - It completes in the first cycle where rx_count>=4. That cycle pops 4 bytes at once, and in_data_e = {mem[rp+3],mem[rp+2],mem[rp+1],mem[rp]}, with indices modulo DEPTH.
  - in_data_e is 0 in every cycle where cin_int does not complete.
  - Push and pop in the same cycle: rx_count_next = rx_count + 1 - 4. The pushed byte is not visible to that same pop.
- out:
  - io_stall = out_issued_e && tx_count==DEPTH. There is no full-bypass; a head pop in the same cycle does not unstall the push.
  - It completes in the first non-full cycle and pushes out_data_e[7:0] at wp.
  - Push and pop in the same cycle: tx_count is unchanged.
- Transmit side:
  - tx_valid = (tx_count!=0) and is combinational from the registered count.
  - tx_data = mem[tx_rp] when tx_valid is high, otherwise 0.
  - A pop occurs when tx_valid && tx_ready.
  - A byte pushed in cycle N is visible on tx_data at N+1 at the earliest.
- While io_stall=1, the pipeline holds in_issued_e, out_issued_e and out_data_e stable. The block keeps no per-instruction state: completion is defined purely by the current-cycle conditions.
- in_issued_e and out_issued_e together is illegal; the decoder never produces it. The bench asserts on it.
- Simultaneous rx push and tx traffic are fully independent of each other.

Test Plan:
- Reset, then in_issued_e=1 with no rx → io_stall=1 every cycle. Then strobe 0x78, 0x56, 0x34, 0x12 → io_stall drops in the cycle after the 4th push, and in_data_e=0x12345678 in that cycle with rx_count back to 0.
- Four out instructions with out_data_e=0xAABBCC01..04 and tx_ready=0 → tx_valid=1 and tx_data=0x01. Then raise tx_ready → 0x01, 0x02, 0x03, 0x04 are delivered on consecutive cycles, followed by tx_valid=0.
- DEPTH_LOG2=2 with tx_ready=0: the 5th out stalls. Pulse tx_ready for one cycle → the stall clears the next cycle and the 5th byte is queued behind the 3 remaining.
- DEPTH_LOG2=2: push 5 rx bytes → rx_overrun=1 and the 5th byte is dropped. Then cin_int with a simultaneous rx_valid=0x99 → result is bytes 1..4, rx_count=1, and a second cin_int later returns 0x99 as its low byte.
- Pointer wrap with DEPTH_LOG2=2: perform 3 cin_int of 4 bytes each with varying values → every result is correct across the wrap-around.
- Assert rst mid-stall with in_issued_e=1 and rx_count=2 → the next cycle shows rx_count=0, rx_overrun=0, tx_valid=0, and no pop occurred.
